// File: rtl/turbo_pkg.sv
// Shared constants, FSM state type and tap-parity helper for the turbo encoder
// constituent encoders (LTE / NB-IoT uplink).
package turbo_pkg;

  localparam int          M_LTE    = 3;
  localparam logic [3:0]  G_FB_LTE = 4'b1101;  // 1 + D^2 + D^3
  localparam logic [3:0]  G_FF_LTE = 4'b1011;  // 1 + D + D^3
  localparam int          K_MAX_NB = 6144;

  // Polynomials and state vectors are zero-extended to this width before tapping.
  localparam int          POLY_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } state_t;

  // XOR of the state bits selected by the polynomial coefficients.
  function automatic logic tap_xor(input logic [POLY_W-1:0] poly,
                                   input logic [POLY_W-1:0] taps);
    return ^(poly & taps);
  endfunction

endpackage

// File: rtl/rsc_core.sv
// Combinational RSC trellis step: feedback bit a, parity z and the systematic
// bit x (the information bit, or the zero-forcing tail bit in tail mode).
module rsc_core
  import turbo_pkg::*;
#(
  parameter int         M    = M_LTE,
  parameter logic [M:0] G_FB = G_FB_LTE,
  parameter logic [M:0] G_FF = G_FF_LTE
) (
  input  logic       u,
  input  logic [M:1] s,
  input  logic       tail_mode,
  output logic       x,
  output logic       a,
  output logic       z
);

  // Bit 0 of each polynomial multiplies a (not a delay element), so it is
  // excluded from the state taps and handled separately.
  localparam logic [POLY_W-1:0] FB_TAPS = POLY_W'(G_FB) & ~POLY_W'(1);
  localparam logic [POLY_W-1:0] FF_TAPS = POLY_W'(G_FF) & ~POLY_W'(1);

  logic [POLY_W-1:0] s_ext;
  logic              fb;

  assign s_ext = POLY_W'({s, 1'b0});
  assign fb    = tap_xor(FB_TAPS, s_ext);

  // In tail mode x equals the feedback sum, which makes a zero.
  assign x = tail_mode ? fb : u;
  assign a = x ^ fb;
  assign z = (G_FF[0] & a) ^ tap_xor(FF_TAPS, s_ext);

endmodule

// File: rtl/rsc_encoder_stream.sv
// Streaming RSC constituent encoder: valid/ready in and out, runtime block
// length, and M trellis-termination beats appended to every block.
module rsc_encoder_stream
  import turbo_pkg::*;
#(
  parameter int         K_MAX = K_MAX_NB,
  parameter int         KW    = 13,
  parameter int         M     = M_LTE,
  parameter logic [M:0] G_FB  = G_FB_LTE,
  parameter logic [M:0] G_FF  = G_FF_LTE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sys,
  output logic          out_par,
  output logic          out_tail,
  output logic          out_last,
  output logic          busy,
  output logic          len_err
);

  state_t        state, state_nxt;
  logic [M:1]    s;
  logic [KW-1:0] cnt;
  logic [KW-1:0] klen;

  logic adv, accept, tail_step, load, last_step, len_ok, start_ok;
  logic x, a, z;

  rsc_core #(
    .M    (M),
    .G_FB (G_FB),
    .G_FF (G_FF)
  ) u_core (
    .u         (in_bit),
    .s         (s),
    .tail_mode (state == TAIL),
    .x         (x),
    .a         (a),
    .z         (z)
  );

  assign adv       = !out_valid || out_ready;
  assign in_ready  = (state == DATA) && adv;
  assign accept    = in_valid && in_ready;
  assign tail_step = (state == TAIL) && adv;
  assign load      = accept || tail_step;
  assign last_step = ((state == DATA) && (cnt == klen - KW'(1))) ||
                     ((state == TAIL) && (cnt == KW'(M - 1)));
  assign len_ok    = (k_len != '0) && (k_len <= KW'(K_MAX));
  assign start_ok  = (state == IDLE) && start && len_ok;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of a combinational block is assigned a default first so
  // that no path through the case statement leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)           state_nxt = DATA;
      DATA:    if (accept && last_step) state_nxt = TAIL;
      TAIL:    if (adv && last_step)    state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s         <= '0;
      cnt       <= '0;
      klen      <= '0;
      out_valid <= 1'b0;
      out_sys   <= 1'b0;
      out_par   <= 1'b0;
      out_tail  <= 1'b0;
      out_last  <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      len_err <= (state == IDLE) && start && !len_ok;

      if (start_ok) begin
        klen <= k_len;
        s    <= '0;
        cnt  <= '0;
      end else if (load) begin
        s   <= {s[M-1:1], a};
        cnt <= last_step ? '0 : cnt + KW'(1);
      end

      // A held beat (including the final tail beat) survives a new start;
      // it only retires through its own handshake.
      if (load) begin
        out_valid <= 1'b1;
        out_sys   <= x;
        out_par   <= z;
        out_tail  <= (state == TAIL);
        out_last  <= (state == TAIL) && last_step;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rsc_encoder_stream.sv
// Self-checking bench for rsc_encoder_stream: scoreboard of expected beats
// compared on every output handshake, plus per-scenario inline checks.
module tb_rsc_encoder_stream;

  localparam int KW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          in_valid;
  logic          in_ready;
  logic          in_bit;
  logic          out_valid;
  logic          out_ready;
  logic          out_sys;
  logic          out_par;
  logic          out_tail;
  logic          out_last;
  logic          busy;
  logic          len_err;

  rsc_encoder_stream dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sys   (out_sys),
    .out_par   (out_par),
    .out_tail  (out_tail),
    .out_last  (out_last),
    .busy      (busy),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sys;
    logic par;
    logic tail;
    logic last;
  } beat_t;

  beat_t exp_q[$];
  logic  blk_bits[$];
  int    checks = 0;
  int    errors = 0;
  logic  bp_done;

  // Encoder model written straight from the trellis equations of 1+D^2+D^3 / 1+D+D^3.
  localparam logic [3:0] GFB = 4'b1101;
  localparam logic [3:0] GFF = 4'b1011;

  function automatic beat_t mk(input logic sys, par, tail, last);
    beat_t b;
    b.sys = sys; b.par = par; b.tail = tail; b.last = last;
    return b;
  endfunction

  task automatic push_model(input int k);
    logic [3:0] st;
    logic fb, u, av, zv;
    st = '0;
    for (int i = 0; i < k + 3; i++) begin
      fb = (GFB[1] & st[1]) ^ (GFB[2] & st[2]) ^ (GFB[3] & st[3]);
      u  = (i < k) ? blk_bits[i] : fb;
      av = u ^ fb;
      zv = (GFF[0] & av) ^ (GFF[1] & st[1]) ^ (GFF[2] & st[2]) ^ (GFF[3] & st[3]);
      exp_q.push_back(mk(u, zv, i >= k, i == k + 2));
      st = {st[2:1], av, 1'b0};
    end
  endtask

  // Scoreboard and stall monitor, sampled on the falling edge.
  beat_t prev_beat;
  logic  stalled = 1'b0;
  always @(negedge clk) begin
    beat_t cur, e;
    cur = mk(out_sys, out_par, out_tail, out_last);
    if (rst !== 1'b1) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || cur !== prev_beat) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b beat=%b, need valid=1 beat=%b", out_valid, cur, prev_beat);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: got %b, need 0", in_ready);
        end
      end
      stalled   = out_valid && !out_ready;
      prev_beat = cur;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got sys/par/tail/last=%b, need no beat", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL beat: got sys/par/tail/last=%b, need %b", cur, e);
          end
        end
      end
    end
  end

  task automatic send_block(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    k_len = KW'(k);
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b, need 1", busy);
    end
    for (int i = 0; i < k; i++) begin
      in_valid = 1'b1;
      in_bit   = blk_bits[i];
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got 0, need 1 within 200 cycles");
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy || out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: got pending=%0d busy=%b valid=%b, need 0 0 0", exp_q.size(), busy, out_valid);
    end
  endtask

  task automatic push_impulse();
    logic [6:0] sys_v;
    sys_v = 7'b1010001;  // beat i in bit i: 1,0,0,0,1,0,1
    blk_bits = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) exp_q.push_back(mk(sys_v[i], 1'b1, i >= 4, i == 6));
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    #12;
    checks++;
    if ({out_valid, out_sys, out_par, out_tail, out_last, busy, len_err, in_ready} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, need 00000000",
               {out_valid, out_sys, out_par, out_tail, out_last, busy, len_err, in_ready});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    push_impulse();
    send_block(4);
    wait_drain();
    checks++;
    if (dut.s !== 3'b000) begin
      errors++;
      $display("FAIL impulse_final_state: got %b, need 000", dut.s);
    end
  endtask

  task automatic test_zero_block();
    blk_bits = {};
    for (int i = 0; i < 40; i++) blk_bits.push_back(1'b0);
    for (int i = 0; i < 43; i++) exp_q.push_back(mk(1'b0, 1'b0, i >= 40, i == 42));
    send_block(40);
    wait_drain();
  endtask

  task automatic test_backpressure();
    push_impulse();
    bp_done = 1'b0;
    fork
      begin
        send_block(4);
        wait_drain();
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk); #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_len_err();
    int bad[2];
    bad[0] = 0;
    bad[1] = 6145;
    foreach (bad[j]) begin
      start = 1'b1;
      k_len = KW'(bad[j]);
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({len_err, busy, out_valid} !== 3'b100) begin
        errors++;
        $display("FAIL len_err_pulse k=%0d: got err/busy/valid=%b, need 100", bad[j], {len_err, busy, out_valid});
      end
      @(posedge clk); #1;
      checks++;
      if ({len_err, busy, out_valid} !== 3'b000) begin
        errors++;
        $display("FAIL len_err_clear k=%0d: got err/busy/valid=%b, need 000", bad[j], {len_err, busy, out_valid});
      end
    end
  endtask

  task automatic test_back_to_back();
    blk_bits = '{1'b1, 1'b1, 1'b0, 1'b1};
    push_model(4);
    send_block(4);
    blk_bits = '{1'b0, 1'b1, 1'b1, 1'b1};
    push_model(4);
    send_block(4);
    wait_drain();
  endtask

  task automatic test_random_block();
    blk_bits = {};
    for (int i = 0; i < 25; i++) blk_bits.push_back(1'($urandom_range(0, 1)));
    push_model(25);
    send_block(25);
    wait_drain();
  endtask

  task automatic test_reset_mid_block();
    start = 1'b1;
    k_len = KW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(posedge clk); #1;
    in_bit   = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sys, out_par, out_tail, out_last, busy, len_err, in_ready} !== 8'b0) begin
      errors++;
      $display("FAIL reset_mid_block: got %b, need 00000000",
               {out_valid, out_sys, out_par, out_tail, out_last, busy, len_err, in_ready});
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_first_beat: got %0d pending, need 0", exp_q.size());
      exp_q = {};
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    blk_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    push_model(5);
    send_block(5);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_zero_block();
    test_backpressure();
    test_len_err();
    test_back_to_back();
    test_random_block();
    test_reset_mid_block();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
